// File: rtl/proc_pkg.sv
// Shared encodings for the multicycle processor control unit:
// state codes, opcodes, ALU operation and ALU B-mux select values.
package proc_pkg;

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_ALU_EX = 4'd3,
      S_ALU_WB = 4'd4,
      S_LD_MEM = 4'd5,
      S_LD_WB  = 4'd6,
      S_STORE  = 4'd7,
      S_ORI_EX = 4'd8,
      S_ORI_WB = 4'd9,
      S_BR     = 4'd10,
      S_STOP   = 4'd11
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0010;
   localparam logic [3:0] OP_ADD   = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_NAND  = 4'b1000;
   localparam logic [3:0] OP_BZ    = 4'b0101;
   localparam logic [3:0] OP_BNZ   = 4'b1001;
   localparam logic [3:0] OP_BPZ   = 4'b1101;
   localparam logic [3:0] OP_STOP  = 4'b0001;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_NAND = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;

   localparam logic [2:0] ALUB_REG  = 3'b000;
   localparam logic [2:0] ALUB_ONE  = 3'b001;
   localparam logic [2:0] ALUB_IMM4 = 3'b010;
   localparam logic [2:0] ALUB_IMM5 = 3'b011;

   typedef struct packed {
      logic       pc_write;
      logic       addr_sel;
      logic       mem_read;
      logic       mem_write;
      logic       ir_load;
      logic       mdr_load;
      logic       ra_sel;
      logic       rf_write;
      logic       reg_in;
      logic       ab_ld;
      logic       alu_a;
      logic       flag_write;
      logic       alu_out_ld;
      logic [2:0] alu_b;
      logic [2:0] alu_op;
   } ctrl_t;

   // ORI owns every opcode ending in 111 (upper bits carry imm5).
   function automatic logic is_ori(input logic [3:0] op);
      return op[2:0] == 3'b111;
   endfunction

endpackage

// File: rtl/proc_ctrl_decode.sv
// Combinational state/opcode/flag decode: produces datapath controls,
// next state and the instruction-retire pulse for the control FSM.
module proc_ctrl_decode
   import proc_pkg::*;
(
   input  state_t     state,
   input  logic [3:0] op,
   input  logic       n,
   input  logic       z,
   output ctrl_t      ctrl,
   output state_t     next_state,
   output logic       retire
);

   logic taken;

   assign taken = (op == OP_BZ  &&  z) ||
                  (op == OP_BNZ && !z) ||
                  (op == OP_BPZ && !n);

   always_comb begin
      ctrl       = '0;
      next_state = state;
      case (state)
         S_RESET: next_state = S_FETCH;
         S_FETCH: begin
            ctrl.mem_read = 1'b1;
            ctrl.ir_load  = 1'b1;
            ctrl.alu_b    = ALUB_ONE;
            ctrl.alu_op   = ALU_ADD;
            ctrl.pc_write = 1'b1;
            next_state    = S_DECODE;
         end
         S_DECODE: begin
            ctrl.ab_ld  = 1'b1;
            ctrl.ra_sel = is_ori(op);
            if (is_ori(op)) next_state = S_ORI_EX;
            else begin
               case (op)
                  OP_LOAD:                next_state = S_LD_MEM;
                  OP_STORE:               next_state = S_STORE;
                  OP_ADD, OP_SUB, OP_NAND: next_state = S_ALU_EX;
                  OP_BZ, OP_BNZ, OP_BPZ:  next_state = S_BR;
                  OP_STOP:                next_state = S_STOP;
                  default:                next_state = S_FETCH;
               endcase
            end
         end
         S_ALU_EX: begin
            ctrl.alu_a      = 1'b1;
            ctrl.alu_b      = ALUB_REG;
            ctrl.alu_op     = (op == OP_SUB)  ? ALU_SUB  :
                              (op == OP_NAND) ? ALU_NAND : ALU_ADD;
            ctrl.alu_out_ld = 1'b1;
            ctrl.flag_write = 1'b1;
            next_state      = S_ALU_WB;
         end
         S_ALU_WB: begin
            ctrl.rf_write = 1'b1;
            next_state    = S_FETCH;
         end
         S_LD_MEM: begin
            ctrl.addr_sel = 1'b1;
            ctrl.mem_read = 1'b1;
            ctrl.mdr_load = 1'b1;
            next_state    = S_LD_WB;
         end
         S_LD_WB: begin
            ctrl.rf_write = 1'b1;
            ctrl.reg_in   = 1'b1;
            next_state    = S_FETCH;
         end
         S_STORE: begin
            ctrl.addr_sel  = 1'b1;
            ctrl.mem_write = 1'b1;
            next_state     = S_FETCH;
         end
         S_ORI_EX: begin
            ctrl.alu_a      = 1'b1;
            ctrl.alu_b      = ALUB_IMM5;
            ctrl.alu_op     = ALU_OR;
            ctrl.alu_out_ld = 1'b1;
            ctrl.flag_write = 1'b1;
            next_state      = S_ORI_WB;
         end
         S_ORI_WB: begin
            ctrl.rf_write = 1'b1;
            ctrl.ra_sel   = 1'b1;
            next_state    = S_FETCH;
         end
         S_BR: begin
            if (taken) begin
               ctrl.alu_b    = ALUB_IMM4;
               ctrl.alu_op   = ALU_ADD;
               ctrl.pc_write = 1'b1;
            end
            next_state = S_FETCH;
         end
         S_STOP:  next_state = S_STOP;
         default: next_state = S_RESET;
      endcase
   end

   // Every return to fetch except the one out of reset ends an instruction;
   // STOP retires once on entry and never again.
   assign retire = (next_state == S_FETCH && state != S_RESET) ||
                   (next_state == S_STOP  && state != S_STOP);

endmodule

// File: rtl/proc_control_fsm.sv
// Multicycle control unit: state register, Advance gating of write/load
// strobes, and the retired-instruction counter.
//  state    | meaning
//  S_RESET  | idle after reset, go fetch
//  S_FETCH  | read IR from M[PC], PC <= PC+1
//  S_DECODE | load A/B from register file, dispatch on opcode
//  S_ALU_EX | ADD/SUB/NAND into ALUout, update flags
//  S_ALU_WB | write ALUout to Rx
//  S_LD_MEM | read M[Ry] into MDR
//  S_LD_WB  | write MDR to Rx
//  S_STORE  | write Rx to M[Ry]
//  S_ORI_EX | R1 | imm5 into ALUout, update flags
//  S_ORI_WB | write ALUout to R1
//  S_BR     | conditional PC <= PC + sext(imm4)
//  S_STOP   | halted until reset
module proc_control_fsm
   import proc_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             CLOCK_50,
   input  logic             Resetn,
   input  logic             Advance,
   input  logic [7:0]       OpCode,
   input  logic             N,
   input  logic             Z,
   output logic             PCwrite,
   output logic             AddrSel,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRload,
   output logic             MDRload,
   output logic             RASel,
   output logic             RFWrite,
   output logic             RegIn,
   output logic             ABLD,
   output logic             ALU_A,
   output logic             FlagWrite,
   output logic             ALUoutLD,
   output logic [2:0]       ALU_B,
   output logic [2:0]       ALUop,
   output logic [3:0]       State,
   output logic             Halted,
   output logic [CNT_W-1:0] InstrCount
);

   state_t     state_q;
   state_t     next_state;
   ctrl_t      ctrl;
   ctrl_t      ctrl_gated;
   logic       retire;
   logic       unused_imm;

   // Immediate and register fields go straight to the datapath.
   assign unused_imm = ^OpCode[7:4];

   proc_ctrl_decode u_decode (
      .state      (state_q),
      .op         (OpCode[3:0]),
      .n          (N),
      .z          (Z),
      .ctrl       (ctrl),
      .next_state (next_state),
      .retire     (retire)
   );

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= S_RESET;
         InstrCount <= '0;
      end else if (Advance) begin
         state_q <= next_state;
         if (retire) InstrCount <= InstrCount + CNT_W'(1);
      end
   end

   // A stalled cycle must not write anything; mux selects stay valid.
   always_comb begin
      ctrl_gated = ctrl;
      if (!Advance) begin
         ctrl_gated.pc_write   = 1'b0;
         ctrl_gated.mem_write  = 1'b0;
         ctrl_gated.mem_read   = 1'b0;
         ctrl_gated.ir_load    = 1'b0;
         ctrl_gated.mdr_load   = 1'b0;
         ctrl_gated.rf_write   = 1'b0;
         ctrl_gated.ab_ld      = 1'b0;
         ctrl_gated.flag_write = 1'b0;
         ctrl_gated.alu_out_ld = 1'b0;
      end
   end

   assign PCwrite   = ctrl_gated.pc_write;
   assign AddrSel   = ctrl_gated.addr_sel;
   assign MemRead   = ctrl_gated.mem_read;
   assign MemWrite  = ctrl_gated.mem_write;
   assign IRload    = ctrl_gated.ir_load;
   assign MDRload   = ctrl_gated.mdr_load;
   assign RASel     = ctrl_gated.ra_sel;
   assign RFWrite   = ctrl_gated.rf_write;
   assign RegIn     = ctrl_gated.reg_in;
   assign ABLD      = ctrl_gated.ab_ld;
   assign ALU_A     = ctrl_gated.alu_a;
   assign FlagWrite = ctrl_gated.flag_write;
   assign ALUoutLD  = ctrl_gated.alu_out_ld;
   assign ALU_B     = ctrl_gated.alu_b;
   assign ALUop     = ctrl_gated.alu_op;
   assign State     = state_q;
   assign Halted    = (state_q == S_STOP);

endmodule
